// File: rtl/ula_sequenciador_if.sv
// Command, ULA-drive and result buses between the sequencer and its environment.
// The master modport is the sequencer; slave is the operation source, ULA and result consumer.
interface ula_sequenciador_if #(
  parameter int unsigned W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [1:0]   cmd_f;

  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic [1:0]   ula_f;
  logic [W-1:0] ula_saida;
  logic         ula_flag_o;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_saida;
  logic         res_flag_o;
  logic [1:0]   res_f;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_f, ula_saida, ula_flag_o, res_ready,
    output cmd_ready, ula_a, ula_b, ula_f, res_valid, res_saida, res_flag_o, res_f
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_f, ula_saida, ula_flag_o, res_ready,
    input  cmd_ready, ula_a, ula_b, ula_f, res_valid, res_saida, res_flag_o, res_f
  );
endinterface

// File: rtl/ula_sequenciador.sv
// Issues one operation at a time to the combinational ULA, captures its result,
// cross-checks it against an internal model and counts overflow events.
module ula_sequenciador #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  ula_sequenciador_if.master bus,
  output logic [CNT_W-1:0] ovf_count,
  output logic             chk_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [W-1:0]     ula_a_q, ula_a_d;
  logic [W-1:0]     ula_b_q, ula_b_d;
  logic [1:0]       ula_f_q, ula_f_d;
  logic [W-1:0]     exp_saida_q, exp_saida_d;
  logic             exp_flag_q, exp_flag_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_saida_q, res_saida_d;
  logic             res_flag_q, res_flag_d;
  logic [1:0]       res_f_q, res_f_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             chk_err_q, chk_err_d;

  logic [W-1:0]     sum_c, diff_c, mdl_saida_c;
  logic             mdl_flag_c;

  // Reference result/overflow for the command being offered, wrap-around on W bits.
  always_comb begin
    sum_c       = W'(bus.cmd_a + bus.cmd_b);
    diff_c      = W'(bus.cmd_a - bus.cmd_b);
    mdl_saida_c = '0;
    mdl_flag_c  = 1'b0;
    unique case (bus.cmd_f)
      2'b00: mdl_saida_c = bus.cmd_a & bus.cmd_b;
      2'b01: mdl_saida_c = bus.cmd_a | bus.cmd_b;
      2'b10: begin
        mdl_saida_c = sum_c;
        mdl_flag_c  = (bus.cmd_a[W-1] == bus.cmd_b[W-1]) && (sum_c[W-1] != bus.cmd_a[W-1]);
      end
      default: begin
        mdl_saida_c = diff_c;
        mdl_flag_c  = (bus.cmd_a[W-1] != bus.cmd_b[W-1]) && (diff_c[W-1] != bus.cmd_a[W-1]);
      end
    endcase
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_f_d     = ula_f_q;
    exp_saida_d = exp_saida_q;
    exp_flag_d  = exp_flag_q;
    res_valid_d = res_valid_q;
    res_saida_d = res_saida_q;
    res_flag_d  = res_flag_q;
    res_f_d     = res_f_q;
    ovf_d       = ovf_q;
    chk_err_d   = chk_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d     = ISSUE;
          ula_a_d     = bus.cmd_a;
          ula_b_d     = bus.cmd_b;
          ula_f_d     = bus.cmd_f;
          exp_saida_d = mdl_saida_c;
          exp_flag_d  = mdl_flag_c;
        end
      end
      ISSUE: begin
        state_d     = DONE;
        res_saida_d = bus.ula_saida;
        res_flag_d  = bus.ula_flag_o;
        res_f_d     = ula_f_q;
        res_valid_d = 1'b1;
        if ((bus.ula_saida != exp_saida_q) || (bus.ula_flag_o != exp_flag_q)) begin
          chk_err_d = 1'b1;
        end
        // Counts the flag the ULA reported, saturating at all-ones.
        if (bus.ula_flag_o && (ovf_q != CNT_MAX)) begin
          ovf_d = ovf_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_f_q     <= '0;
      exp_saida_q <= '0;
      exp_flag_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_saida_q <= '0;
      res_flag_q  <= 1'b0;
      res_f_q     <= '0;
      ovf_q       <= '0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_f_q     <= ula_f_d;
      exp_saida_q <= exp_saida_d;
      exp_flag_q  <= exp_flag_d;
      res_valid_q <= res_valid_d;
      res_saida_q <= res_saida_d;
      res_flag_q  <= res_flag_d;
      res_f_q     <= res_f_d;
      ovf_q       <= ovf_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.ula_a      = ula_a_q;
  assign bus.ula_b      = ula_b_q;
  assign bus.ula_f      = ula_f_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_saida  = res_saida_q;
  assign bus.res_flag_o = res_flag_q;
  assign bus.res_f      = res_f_q;
  assign ovf_count      = ovf_q;
  assign chk_err        = chk_err_q;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Bench for ula_sequenciador: two instances (8-bit and 2-bit overflow counter) share stimulus,
// each driving its own behavioural ULA; results compared against a transaction-level model.
module tb_ula_sequenciador;

  logic clock;
  logic reset;
  bit   fault_en;

  int tests;
  int fails;
  int ovf_cnt;
  bit err_mdl;

  ula_sequenciador_if #(.W(8)) bus8 ();
  ula_sequenciador_if #(.W(8)) bus2 ();

  logic [7:0] ovf8;
  logic [1:0] ovf2;
  logic       err8, err2;
  logic [8:0] u8, u2;

  ula_sequenciador #(.W(8), .CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .bus(bus8), .ovf_count(ovf8), .chk_err(err8)
  );
  ula_sequenciador #(.W(8), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2), .ovf_count(ovf2), .chk_err(err2)
  );

  // Signed-integer ULA: overflow means the true result leaves the 8-bit range.
  function automatic logic [8:0] ula_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] f, input bit fault);
    int sa, sb, r;
    logic [7:0] s;
    logic fl;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 0;
    s  = '0;
    fl = 1'b0;
    case (f)
      2'd0: s = a & b;
      2'd1: s = a | b;
      2'd2: begin r = sa + sb; s = r[7:0]; fl = (r > 127) || (r < -128); if (fault) fl = 1'b0; end
      default: begin r = sa - sb; s = r[7:0]; fl = (r > 127) || (r < -128); end
    endcase
    return {fl, s};
  endfunction

  always_comb u8 = ula_ref(bus8.ula_a, bus8.ula_b, bus8.ula_f, fault_en);
  always_comb u2 = ula_ref(bus2.ula_a, bus2.ula_b, bus2.ula_f, fault_en);
  assign bus8.ula_saida  = u8[7:0];
  assign bus8.ula_flag_o = u8[8];
  assign bus2.ula_saida  = u2[7:0];
  assign bus2.ula_flag_o = u2[8];

  assign bus2.cmd_valid = bus8.cmd_valid;
  assign bus2.cmd_a     = bus8.cmd_a;
  assign bus2.cmd_b     = bus8.cmd_b;
  assign bus2.cmd_f     = bus8.cmd_f;
  assign bus2.res_ready = bus8.res_ready;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string tag);
    check({tag, "_ovf8"}, 32'(ovf8), (ovf_cnt > 255) ? 255 : ovf_cnt);
    check({tag, "_ovf2"}, 32'(ovf2), (ovf_cnt > 3) ? 3 : ovf_cnt);
    check({tag, "_err8"}, 32'(err8), 32'(err_mdl));
    check({tag, "_err2"}, 32'(err2), 32'(err_mdl));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus8.cmd_valid = 1'b0;
    bus8.res_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 32'(bus8.cmd_ready), 1);
    check("rst_res_valid", 32'(bus8.res_valid), 0);
    check("rst_ula_a", 32'(bus8.ula_a), 0);
    check("rst_ula_b", 32'(bus8.ula_b), 0);
    check("rst_ula_f", 32'(bus8.ula_f), 0);
    check("rst_res_saida", 32'(bus8.res_saida), 0);
    ovf_cnt = 0;
    err_mdl = 1'b0;
    expect_state("rst");
    reset = 1'b0;
  endtask

  // One full transaction; exp_* are the values the ULA is expected to return.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f,
                       input int hold, input logic [7:0] exp_s, input logic exp_fl);
    int n;
    @(negedge clock);
    bus8.cmd_a = a;
    bus8.cmd_b = b;
    bus8.cmd_f = f;
    bus8.cmd_valid = 1'b1;
    bus8.res_ready = 1'b0;
    n = 0;
    while (!bus8.cmd_ready && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (!bus8.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
      bus8.cmd_valid = 1'b0;
      return;
    end
    @(negedge clock);
    bus8.cmd_valid = 1'b0;
    check("iss_res_valid", 32'(bus8.res_valid), 0);
    check("iss_cmd_ready", 32'(bus8.cmd_ready), 0);
    check("iss_ula_a", 32'(bus8.ula_a), 32'(a));
    check("iss_ula_b", 32'(bus8.ula_b), 32'(b));
    check("iss_ula_f", 32'(bus8.ula_f), 32'(f));
    if ({exp_fl, exp_s} != ula_ref(a, b, f, 1'b0)) err_mdl = 1'b1;
    if (exp_fl) ovf_cnt++;
    @(negedge clock);
    check("res_valid", 32'(bus8.res_valid), 1);
    check("res_saida", 32'(bus8.res_saida), 32'(exp_s));
    check("res_flag", 32'(bus8.res_flag_o), 32'(exp_fl));
    check("res_f", 32'(bus8.res_f), 32'(f));
    check("res_saida2", 32'(bus2.res_saida), 32'(exp_s));
    expect_state("res");
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_valid", 32'(bus8.res_valid), 1);
      check("hold_saida", 32'(bus8.res_saida), 32'(exp_s));
      check("hold_cmd_ready", 32'(bus8.cmd_ready), 0);
    end
    bus8.res_ready = 1'b1;
    @(negedge clock);
    bus8.res_ready = 1'b0;
    check("ret_res_valid", 32'(bus8.res_valid), 0);
    check("ret_cmd_ready", 32'(bus8.cmd_ready), 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] f;
    logic [7:0] exp_s;
    logic       exp_fl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rf;
    logic [8:0] rr;

    tests = 0;
    fails = 0;
    ovf_cnt = 0;
    err_mdl = 1'b0;
    fault_en = 1'b0;
    reset = 1'b1;
    bus8.cmd_valid = 1'b0;
    bus8.cmd_a = '0;
    bus8.cmd_b = '0;
    bus8.cmd_f = '0;
    bus8.res_ready = 1'b0;

    vecs[0] = '{8'h64, 8'h32, 2'd2, 8'h96, 1'b1};
    vecs[1] = '{8'h80, 8'h01, 2'd3, 8'h7F, 1'b1};
    vecs[2] = '{8'h05, 8'h07, 2'd3, 8'hFE, 1'b0};
    vecs[3] = '{8'hF0, 8'h3C, 2'd0, 8'h30, 1'b0};
    vecs[4] = '{8'h0F, 8'hA0, 2'd1, 8'hAF, 1'b0};
    vecs[5] = '{8'hFF, 8'h01, 2'd2, 8'h00, 1'b0};
    vecs[6] = '{8'h7F, 8'hFF, 2'd3, 8'h80, 1'b1};
    vecs[7] = '{8'h80, 8'h80, 2'd2, 8'h00, 1'b1};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, i % 3, vecs[i].exp_s, vecs[i].exp_fl);
    end

    // Result held under back-pressure while a new command waits on cmd_valid.
    @(negedge clock);
    bus8.cmd_a = 8'hF0; bus8.cmd_b = 8'h3C; bus8.cmd_f = 2'd0;
    bus8.cmd_valid = 1'b1;
    bus8.res_ready = 1'b0;
    check("bp_idle_ready", 32'(bus8.cmd_ready), 1);
    @(negedge clock);
    bus8.cmd_a = 8'h0F; bus8.cmd_b = 8'h11; bus8.cmd_f = 2'd1;
    @(negedge clock);
    check("bp_saida", 32'(bus8.res_saida), 32'h30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_cmd_ready", 32'(bus8.cmd_ready), 0);
      check("bp_res_valid", 32'(bus8.res_valid), 1);
      check("bp_hold_saida", 32'(bus8.res_saida), 32'h30);
      check("bp_ula_a", 32'(bus8.ula_a), 32'hF0);
    end
    bus8.res_ready = 1'b1;
    @(negedge clock);
    bus8.res_ready = 1'b0;
    check("bp_back_valid", 32'(bus8.res_valid), 0);
    check("bp_back_ready", 32'(bus8.cmd_ready), 1);
    check("bp_not_taken", 32'(bus8.ula_a), 32'hF0);
    @(negedge clock);
    bus8.cmd_valid = 1'b0;
    check("bp2_ula_a", 32'(bus8.ula_a), 32'h0F);
    check("bp2_valid", 32'(bus8.res_valid), 0);
    @(negedge clock);
    check("bp2_res_valid", 32'(bus8.res_valid), 1);
    check("bp2_saida", 32'(bus8.res_saida), 32'h1F);
    check("bp2_f", 32'(bus8.res_f), 1);
    expect_state("bp2");
    bus8.res_ready = 1'b1;
    @(negedge clock);
    bus8.res_ready = 1'b0;
    check("bp2_done", 32'(bus8.res_valid), 0);

    // Faulty ULA drops the ADD overflow flag; chk_err must latch and stay.
    fault_en = 1'b1;
    do_op(8'h7F, 8'h01, 2'd2, 0, 8'h80, 1'b0);
    fault_en = 1'b0;
    check("fault_err8", 32'(err8), 1);
    do_op(8'h01, 8'h02, 2'd2, 1, 8'h03, 1'b0);
    do_op(8'hAA, 8'h55, 2'd1, 0, 8'hFF, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 2'($urandom);
      rr = ula_ref(ra, rb, rf, 1'b0);
      do_op(ra, rb, rf, int'($urandom_range(0, 2)), rr[7:0], rr[8]);
    end

    // Counter saturation and reset in ISSUE.
    do_reset();
    repeat (5) do_op(8'h7F, 8'h01, 2'd2, 0, 8'h80, 1'b1);
    @(negedge clock);
    bus8.cmd_a = 8'h7F; bus8.cmd_b = 8'h01; bus8.cmd_f = 2'd2;
    bus8.cmd_valid = 1'b1;
    @(negedge clock);
    bus8.cmd_valid = 1'b0;
    check("mid_in_issue", 32'(bus8.res_valid), 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ovf_cnt = 0;
    err_mdl = 1'b0;
    check("mid_res_valid", 32'(bus8.res_valid), 0);
    check("mid_res_valid2", 32'(bus2.res_valid), 0);
    check("mid_cmd_ready", 32'(bus8.cmd_ready), 1);
    expect_state("mid");
    @(negedge clock);
    check("mid_no_result", 32'(bus8.res_valid), 0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rf = 2'($urandom);
      rr = ula_ref(ra, rb, rf, 1'b0);
      do_op(ra, rb, rf, int'($urandom_range(0, 1)), rr[7:0], rr[8]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
